load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits directly upstream of the byte-addressed data memory (4096 bytes, combinational read, DMCtrl size/sign encoding).
- Accepts one load/store request at a time from the core datapath over a valid/ready handshake.
- Checks legality, alignment and range, then drives the memory port for a programmable number of cycles.
- Returns the result over a valid/ready response handshake and stalls the core while busy.

Parameters:
- DM_DEPTH, 4096: data memory size in bytes; legal byte addresses are 0..DM_DEPTH-1.
- ACCESS_CYCLES, 1: cycles the memory port is held per access (min 1, max 15).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, low bytes used.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  core consumes the response.
- rsp_rdata  out  32  load data as already extended by memory; 0 for stores and faults.
- rsp_err  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3.
- dm_addr  out  32  memory address.
- dm_wdata  out  32  memory write data.
- dm_ctrl  out  3  memory DMCtrl.
- dm_wr_enable  out  1  memory write strobe.
- dm_rdata  in  32  memory read data.

Behaviour:
- Reset values: state IDLE; req_ready 1; rsp_valid 0; rsp_rdata 0; rsp_err 00; dm_addr 0; dm_wdata 0; dm_ctrl 010; dm_wr_enable 0.
- dm_wr_enable is forced to 0 combinationally in any cycle where rst is high.
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata and evaluate legality.
  - Fault priority: illegal funct3 (store with 100/101/11x, load with 011/11x) > misaligned (H with addr[0]!=0, W with addr[1:0]!=0) > out of range (addr+size-1 >= DM_DEPTH, computed in 33 bits so there is no wrap).
  - Fault -> RESP with rsp_err set and no memory write. Otherwise -> ACCESS with cnt=ACCESS_CYCLES-1.
- ACCESS: req_ready=0. dm_addr/dm_ctrl/dm_wdata are held at the latched values for the whole state.
  - cnt decrements each cycle.
  - When cnt==0: stores assert dm_wr_enable for exactly that one cycle; loads capture dm_rdata into rsp_rdata. Then -> RESP.
- RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready is sampled high, then -> IDLE.
  - The next request may be accepted in the cycle after the handshake, not the same cycle.
- Latency, request accepted at edge 0:
  - ok access: rsp_valid high from edge ACCESS_CYCLES+1.
  - fault: rsp_valid high from edge 1.
- Outside ACCESS, dm_ctrl is 010 and dm_addr holds its last value, giving a harmless read.
- A request is never dropped while req_ready=0. The core must hold req_* stable until accepted.
- Reset mid-ACCESS: transaction abandoned, no write; IDLE after the edge. Reset mid-RESP: response discarded.
- rsp_rdata = 0 for stores and faults.

Decomposition:
- Shared package/include: DMCtrl encodings (B, H, W, BU, HU), rsp_err codes, FSM state encoding.
- One natural sub-module: lsu_check, purely combinational; maps (we, funct3, addr) -> (err, size).
- The FSM, counter and register stage live in load_store_unit.

Test Plan:
- Store W 0xDEADBEEF @0x10, then load W @0x10 (ACCESS_CYCLES=1) -> dm_wr_enable high exactly 1 cycle; load rsp_rdata=0xDEADBEEF, rsp_err=00, rsp_valid at edge 2.
- Store B 0x80 @0x21, then load B and load BU @0x21 -> rsp_rdata 0xFFFFFF80 then 0x00000080.
- Load H @0x3 and store W @0x102 -> rsp_err=01 at edge 1; no dm_wr_enable pulse; memory unchanged.
- Load W @0xFFC (ok, err 00) and @0xFFD; store W @0xFFE; store H @0xFFFFFFFF -> err 01, 01, 01.
  - With the alignment check bypassed via B/H: load H @0xFFF -> 01; load B @0x1000 -> 10.
  - Store funct3=100 -> 11.
- ACCESS_CYCLES=3, rsp_ready held low 5 cycles -> req_ready low throughout; rsp stable; a second req_valid is not accepted until the cycle after the handshake.
- Assert rst during ACCESS of a store W @0x40 -> no dm_wr_enable pulse; mem[0x40] unchanged; outputs at reset values on the next edge.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit.
// DMCtrl sizes, response error codes and FSM states.
package lsu_pkg;

    localparam logic [2:0] DM_B  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_W  = 3'b010;
    localparam logic [2:0] DM_BU = 3'b100;
    localparam logic [2:0] DM_HU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_FUNCT3   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

endpackage

// File: rtl/load_store_unit_check.sv
// Request legality check for the load/store unit.
// Purely combinational: (we, funct3, addr) -> error code.
module lsu_check
    import lsu_pkg::*;
#(
    parameter int DM_DEPTH = 4096
) (
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    output logic [1:0]  err
);

    logic [2:0]  size;
    logic        legal;
    logic        misaligned;
    logic        out_of_range;
    logic [32:0] last_byte;

    // Decode access size, then apply faults in priority order
    always_comb begin
        size  = 3'd1;
        legal = 1'b1;
        unique case (funct3)
            DM_B, DM_BU: size = 3'd1;
            DM_H, DM_HU: size = 3'd2;
            DM_W:        size = 3'd4;
            default: begin
                size  = 3'd1;
                legal = 1'b0;
            end
        endcase
        // Unsigned variants have no meaning for stores
        if (we && funct3[2]) begin
            legal = 1'b0;
        end
        misaligned = ((size == 3'd2) && addr[0]) ||
                     ((size == 3'd4) && (addr[1:0] != 2'b00));
        // 33-bit sum so an access near 2^32 cannot wrap into range
        last_byte    = {1'b0, addr} + {30'b0, size} - 33'd1;
        out_of_range = (last_byte >= 33'(DM_DEPTH));
        if (!legal) begin
            err = ERR_FUNCT3;
        end else if (misaligned) begin
            err = ERR_MISALIGN;
        end else if (out_of_range) begin
            err = ERR_RANGE;
        end else begin
            err = ERR_OK;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the core and the byte-addressed data memory.
// One request at a time; memory port held for ACCESS_CYCLES cycles.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DM_DEPTH      = 4096,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [2:0]  dm_ctrl,
    output logic        dm_wr_enable,
    input  logic [31:0] dm_rdata
);

    localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [2:0]  lat_funct3;
    logic [1:0]  chk_err;
    logic        accept;
    logic        last_cycle;

    lsu_check #(
        .DM_DEPTH (DM_DEPTH)
    ) u_check (
        .we     (req_we),
        .funct3 (req_funct3),
        .addr   (req_addr),
        .err    (chk_err)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (chk_err != ERR_OK) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt == 4'd0) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Memory port: real control only in ACCESS, otherwise a harmless word read
    always_comb begin
        last_cycle   = (state == ST_ACCESS) && (cnt == 4'd0);
        dm_wr_enable = last_cycle && lat_we && !rst;
        dm_ctrl      = (state == ST_ACCESS) ? lat_funct3 : DM_W;
    end

    // Request latch, access counter and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 4'd0;
            lat_we     <= 1'b0;
            lat_funct3 <= DM_W;
            dm_addr    <= 32'h0;
            dm_wdata   <= 32'h0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= ERR_OK;
        end else if (accept) begin
            lat_we     <= req_we;
            lat_funct3 <= req_funct3;
            cnt        <= CNT_INIT;
            rsp_err    <= chk_err;
            rsp_rdata  <= 32'h0;
            // Faulting requests never reach the memory port
            if (chk_err == ERR_OK) begin
                dm_addr  <= req_addr;
                dm_wdata <= req_wdata;
            end
        end else if (state == ST_ACCESS) begin
            if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end else if (!lat_we) begin
                rsp_rdata <= dm_rdata;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit.
// Two instances (1 and 3 access cycles), each with a byte memory.
module tb_load_store_unit;

    localparam int DEPTH = 4096;
    localparam int AC1   = 1;
    localparam int AC3   = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Instance with ACCESS_CYCLES=1
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [2:0]  dm_ctrl;
    logic        dm_wr_enable;
    logic [31:0] dm_rdata;

    // Instance with ACCESS_CYCLES=3
    logic        s_req_valid;
    logic        s_req_ready;
    logic        s_req_we;
    logic [2:0]  s_req_funct3;
    logic [31:0] s_req_addr;
    logic [31:0] s_req_wdata;
    logic        s_rsp_valid;
    logic        s_rsp_ready;
    logic [31:0] s_rsp_rdata;
    logic [1:0]  s_rsp_err;
    logic [31:0] s_dm_addr;
    logic [31:0] s_dm_wdata;
    logic [2:0]  s_dm_ctrl;
    logic        s_dm_wr_enable;
    logic [31:0] s_dm_rdata;

    load_store_unit #(.DM_DEPTH(DEPTH), .ACCESS_CYCLES(AC1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_ctrl      (dm_ctrl),
        .dm_wr_enable (dm_wr_enable),
        .dm_rdata     (dm_rdata)
    );

    load_store_unit #(.DM_DEPTH(DEPTH), .ACCESS_CYCLES(AC3)) dut3 (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (s_req_valid),
        .req_ready    (s_req_ready),
        .req_we       (s_req_we),
        .req_funct3   (s_req_funct3),
        .req_addr     (s_req_addr),
        .req_wdata    (s_req_wdata),
        .rsp_valid    (s_rsp_valid),
        .rsp_ready    (s_rsp_ready),
        .rsp_rdata    (s_rsp_rdata),
        .rsp_err      (s_rsp_err),
        .dm_addr      (s_dm_addr),
        .dm_wdata     (s_dm_wdata),
        .dm_ctrl      (s_dm_ctrl),
        .dm_wr_enable (s_dm_wr_enable),
        .dm_rdata     (s_dm_rdata)
    );

    // Data memories (combinational read, DMCtrl extension)
    logic [7:0]  mem  [DEPTH];
    logic [7:0]  mem3 [DEPTH];
    logic [7:0]  ref_mem [DEPTH];
    logic [11:0] ma;
    logic [11:0] sa;
    int          wr_count = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_rdata;
    logic [1:0]  last_err;

    assign ma = dm_addr[11:0];
    assign sa = s_dm_addr[11:0];

    function automatic logic [31:0] dm_ext(input logic [2:0] c,
                                           input logic [7:0] b0, b1, b2, b3);
        case (c)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b100:  return {24'h0, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b101:  return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    assign dm_rdata = dm_ext(dm_ctrl, mem[ma], mem[ma + 12'd1],
                             mem[ma + 12'd2], mem[ma + 12'd3]);
    assign s_dm_rdata = dm_ext(s_dm_ctrl, mem3[sa], mem3[sa + 12'd1],
                               mem3[sa + 12'd2], mem3[sa + 12'd3]);

    always @(posedge clk) begin
        if (dm_wr_enable) begin
            wr_count <= wr_count + 1;
            mem[ma] <= dm_wdata[7:0];
            if (dm_ctrl[1:0] != 2'b00) mem[ma + 12'd1] <= dm_wdata[15:8];
            if (dm_ctrl[1]) begin
                mem[ma + 12'd2] <= dm_wdata[23:16];
                mem[ma + 12'd3] <= dm_wdata[31:24];
            end
        end
        if (s_dm_wr_enable) begin
            mem3[sa] <= s_dm_wdata[7:0];
            if (s_dm_ctrl[1:0] != 2'b00) mem3[sa + 12'd1] <= s_dm_wdata[15:8];
            if (s_dm_ctrl[1]) begin
                mem3[sa + 12'd2] <= s_dm_wdata[23:16];
                mem3[sa + 12'd3] <= s_dm_wdata[31:24];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: access width in bytes, 0 if funct3 is not a valid size
    function automatic int ref_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [1:0] exp_err(input logic we, input logic [2:0] f3,
                                           input logic [31:0] addr);
        int     sz;
        longint last;
        sz = ref_size(f3);
        if (sz == 0 || (we && f3 >= 3'd4)) return 2'b11;
        if ((longint'(addr) % sz) != 0) return 2'b01;
        last = longint'(addr) + sz - 1;
        if (last >= DEPTH) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                             input logic [31:0] addr);
        longint v;
        int     sz;
        sz = ref_size(f3);
        v  = 0;
        for (int i = 0; i < sz; i++)
            v = v + (longint'(ref_mem[int'(addr) + i]) << (8 * i));
        if (f3[2] == 1'b0 && ((v >> (8 * sz - 1)) & 1) == 1)
            v = v - (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata);
        int sz;
        sz = ref_size(f3);
        for (int i = 0; i < sz; i++)
            ref_mem[int'(addr) + i] = 8'((wdata >> (8 * i)) & 32'hFF);
    endtask

    task automatic mem_same(input string tag);
        int diffs;
        diffs = 0;
        for (int i = 0; i < DEPTH; i++)
            if (mem[i] !== ref_mem[i]) diffs++;
        check(tag, diffs, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check({tag, "_rsp_err"}, rsp_err, 0);
        check({tag, "_dm_addr"}, dm_addr, 0);
        check({tag, "_dm_wdata"}, dm_wdata, 0);
        check({tag, "_dm_ctrl"}, dm_ctrl, 3'b010);
        check({tag, "_dm_wr_enable"}, dm_wr_enable, 0);
    endtask

    // One full request/response on the single-cycle instance
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata);
        logic [1:0]  e;
        logic [31:0] d;
        int          lat;
        int          w0;
        e  = exp_err(we, f3, addr);
        d  = (we || e != 2'b00) ? 32'h0 : ref_load(f3, addr);
        w0 = wr_count;
        check("idle_ready", req_ready, 1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = $urandom();
        req_wdata = $urandom();
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            check("busy_ready", req_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, (e == 2'b00) ? AC1 + 1 : 1);
        check("rsp_err", rsp_err, e);
        check("rsp_rdata", rsp_rdata, d);
        check("resp_req_ready", req_ready, 0);
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            check("rsp_hold_valid", rsp_valid, 1);
            check("rsp_hold_rdata", rsp_rdata, d);
        end
        check("wr_pulses", wr_count - w0, (we && e == 2'b00) ? 1 : 0);
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
        rsp_ready  = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_released", rsp_valid, 0);
        if (we && e == 2'b00) ref_store(f3, addr, wdata);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          w0;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [2:0]  ok_f3 [5];

        ok_f3[0] = 3'b000; ok_f3[1] = 3'b001; ok_f3[2] = 3'b010;
        ok_f3[3] = 3'b100; ok_f3[4] = 3'b101;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 8'h00;
            mem3[i]    = 8'h00;
            ref_mem[i] = 8'h00;
        end
        mem3[16'h10] = 8'h44;
        mem3[16'h11] = 8'h33;
        mem3[16'h12] = 8'h22;
        mem3[16'h13] = 8'h11;

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        s_req_valid = 1'b0; s_req_we = 1'b0; s_req_funct3 = 3'b0;
        s_req_addr = 32'h0; s_req_wdata = 32'h0; s_rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Word store then load back
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        do_req(1'b0, 3'b010, 32'h10, 32'h0);
        check("ldw_value", last_rdata, 32'hDEADBEEF);

        // Byte store, signed and unsigned byte loads
        do_req(1'b1, 3'b000, 32'h21, 32'h12345680);
        do_req(1'b0, 3'b000, 32'h21, 32'h0);
        check("ldb_value", last_rdata, 32'hFFFFFF80);
        do_req(1'b0, 3'b100, 32'h21, 32'h0);
        check("ldbu_value", last_rdata, 32'h00000080);

        // Misaligned accesses, memory untouched
        do_req(1'b0, 3'b001, 32'h3, 32'h0);
        check("ldh_mis_err", last_err, 2'b01);
        do_req(1'b1, 3'b010, 32'h102, 32'hA5A5A5A5);
        check("stw_mis_err", last_err, 2'b01);
        mem_same("mis_mem_same");

        // Top-of-memory boundaries
        do_req(1'b0, 3'b010, 32'hFFC, 32'h0);
        check("ldw_ffc_err", last_err, 2'b00);
        do_req(1'b0, 3'b010, 32'hFFD, 32'h0);
        check("ldw_ffd_err", last_err, 2'b01);
        do_req(1'b1, 3'b010, 32'hFFE, 32'h1);
        check("stw_ffe_err", last_err, 2'b01);
        do_req(1'b1, 3'b001, 32'hFFFFFFFF, 32'h1);
        check("sth_wrap_err", last_err, 2'b01);
        do_req(1'b0, 3'b001, 32'hFFF, 32'h0);
        check("ldh_fff_err", last_err, 2'b01);
        do_req(1'b0, 3'b000, 32'h1000, 32'h0);
        check("ldb_1000_err", last_err, 2'b10);
        do_req(1'b0, 3'b000, 32'hFFF, 32'h0);
        check("ldb_fff_err", last_err, 2'b00);
        do_req(1'b1, 3'b100, 32'h20, 32'h1);
        check("st_f3_err", last_err, 2'b11);
        do_req(1'b0, 3'b011, 32'h20, 32'h0);
        check("ld_f3_err", last_err, 2'b11);
        mem_same("bound_mem_same");

        // Reset in the middle of a store access
        w0 = wr_count;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        req_wdata  = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("access_wr_strobe", dm_wr_enable, 1);
        rst = 1'b1;
        #1;
        check("rst_forces_wr_low", dm_wr_enable, 0);
        @(posedge clk); #1;
        check_reset_values("mid_rst");
        check("mid_rst_no_write", wr_count - w0, 0);
        rst = 1'b0;
        mem_same("mid_rst_mem_same");
        @(posedge clk); #1;

        // Stall behaviour on the three-cycle instance
        s_req_valid  = 1'b1;
        s_req_we     = 1'b0;
        s_req_funct3 = 3'b010;
        s_req_addr   = 32'h10;
        @(posedge clk); #1;
        s_req_funct3 = 3'b000;
        s_req_addr   = 32'h11;
        lat = 1;
        while (!s_rsp_valid && lat < 40) begin
            check("stall_busy", s_req_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        check("stall_latency", lat, AC3 + 1);
        check("stall_err", s_rsp_err, 2'b00);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", s_rsp_valid, 1);
            check("stall_rdata", s_rsp_rdata, 32'h11223344);
            check("stall_ready", s_req_ready, 0);
            @(posedge clk); #1;
        end
        s_rsp_ready = 1'b1;
        @(posedge clk); #1;
        s_rsp_ready = 1'b0;
        check("hs_valid_drop", s_rsp_valid, 0);
        check("hs_not_accepted", s_req_ready, 1);
        @(posedge clk); #1;
        s_req_valid = 1'b0;
        check("second_accepted", s_req_ready, 0);
        lat = 1;
        while (!s_rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("second_latency", lat, AC3 + 1);
        check("second_rdata", s_rsp_rdata, 32'h00000033);
        s_rsp_ready = 1'b1;
        @(posedge clk); #1;
        s_rsp_ready = 1'b0;

        // Randomized traffic against the reference model
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 8)
                f3 = ok_f3[$urandom_range(0, 4)];
            else
                f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0, 1:    addr = 32'($urandom_range(0, 63));
                2:       addr = 32'hFF8 + 32'($urandom_range(0, 11));
                default: addr = $urandom();
            endcase
            do_req(we, f3, addr, $urandom());
        end
        mem_same("final_mem_same");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
